fp_norm_r3: RTL and testbench
=============================

FP_NORM_R3 -- requirements
Module: fp_norm_r3

Interface
REQ-001 The block SHALL have the following ports, listed as name, direction, width, meaning.
  clk  in  1  sole clock; all state updates on rising edge.
  reset_n  in  1  reset; synchronous, active-low.
  in_valid  in  1  input payload valid.
  in_ready  out  1  block can accept the input payload this cycle.
  flush  in  1  synchronous pipeline kill.
  sum_mant  in  28  raw magnitude: [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S.
  exp_in  in  8  biased pre-normalization exponent.
  sign_in, nan_in, inf1_in, inf2_in, sign1_in, sign2_in  in  1 each  result sign and special-case flags, passed through.
  rm_in  in  3  rounding mode, passed through.
  out_valid  out  1  output payload valid.
  out_ready  in  1  downstream rounding stage accepts the output payload.
  exp_norm  out  8  normalized exponent.
  mantissa_norm  out  23  normalized fraction without the hidden bit.
  grs  out  3  guard, round and sticky bits.
  res_is_zero, underflow  out  1 each  zero result and subnormal or underflow indication.
  sign_res, nan, inf1, inf2, sign1, sign2  out  1 each  registered pass-through flags.
  rm  out  3  registered pass-through rounding mode.
REQ-002 The block SHALL use one clock, clk, and a reset, reset_n, that is synchronous and active-low.

Function
REQ-003 The block SHALL be a 2-stage pipeline: stage A registers the payload and lzc, where lzc is the leading-zero count of sum_mant[26:0] in the range 0..27; stage B registers the normalized outputs.
REQ-004 Global advance SHALL be defined as adv = !out_valid || out_ready, and in_ready SHALL equal adv.
REQ-005 When adv=0, both stages and all outputs SHALL hold their values; latency SHALL be 2 cycles from input accept to out_valid, and throughput SHALL be 1 per cycle when unstalled.
REQ-006 When sum_mant is 0, the outputs SHALL be res_is_zero=1, exp_norm=0, mantissa_norm=0, grs=0, underflow=0.
REQ-007 When sum_mant[27]=1 (carry), the block SHALL right-shift by 1:
  mantissa_norm = sum_mant[26:4];
  grs = {sum_mant[3], sum_mant[2], sum_mant[1]|sum_mant[0]};
  exp_norm = min(exp_in+1, 255), computed 9-bit with no wrap.
REQ-008 In the no-carry case with exp_in > lzc, the block SHALL left-shift sum_mant[26:0] by lzc, set exp_norm = exp_in - lzc, and set underflow = 0.
REQ-009 In the no-carry case with exp_in <= lzc and sum_mant nonzero, the block SHALL set underflow = 1 and exp_norm = 0, and left-shift by (exp_in==0 ? 0 : exp_in-1).
REQ-010 After any left shift, the block SHALL take mantissa_norm from shifted[25:3] and grs from shifted[2:0], with shifting zero-filled.
REQ-011 Special flags and rm SHALL pass through unchanged and aligned with the payload; nan, inf1 and inf2 SHALL NOT alter the normalization arithmetic.
REQ-012 When flush=1, both stage-valid bits SHALL clear on the next edge and a simultaneous input SHALL be dropped; flush SHALL take precedence over adv.
REQ-013 Internal exponent arithmetic SHALL be 10-bit signed, and no result SHALL wrap modulo 256.

Reset
REQ-014 With reset_n=0 at an edge, the block SHALL clear out_valid and the stage-A valid bit.
REQ-015 With reset_n=0 at an edge, the block SHALL zero all output data registers.
REQ-016 With reset_n=0 at an edge, in_ready SHALL read 1 on the cycle following reset.
REQ-017 A reset asserted mid-operation SHALL discard in-flight payloads with no output pulse.

Structure
REQ-018 Package fp_pkg SHALL hold:
  EXP_W=8, MANT_W=23, SUM_W=28;
  EXP_MAX=8'd255;
  RM_RNE/RTZ/RDN/RUP/RMM encodings 0..4;
  the packed struct fp_norm_payload_t for the stage-A register.
REQ-019 The leading-zero counter SHALL be the sub-module lzc27: a 27-bit input and a 5-bit count, purely combinational.
REQ-020 The outputs SHALL be directly connectable to round_fp_r4-style rounding inputs.

Verification
REQ-021 Stimulus sum_mant=0x8000000, exp_in=127 -> after 2 cycles, exp_norm=128, mantissa_norm=0, grs=0, underflow=0.
REQ-022 Stimulus sum_mant=0x0000008, exp_in=100 -> exp_norm=77, mantissa_norm=0, grs=0, underflow=0.
REQ-023 Stimulus sum_mant=0x0000008, exp_in=10 -> exp_norm=0, mantissa_norm=0x000200, underflow=1.
REQ-024 Stimulus sum_mant=0x8000000, exp_in=254 -> exp_norm=255; then sum_mant=0 -> res_is_zero=1, exp_norm=0.
REQ-025 Stimulus of three back-to-back inputs with out_ready held low for 3 cycles -> outputs stable, in_ready=0, no loss or duplication, and in-order delivery after release.
REQ-026 Stimulus of flush together with in_valid while both stages are full -> out_valid=0 on the next cycle, and the dropped input never appears.

Source files
------------

// File: rtl/fp_norm_r3_pkg.sv
// fp_pkg: shared widths, rounding-mode encodings and the stage-A payload
// record for the post-add normalizer fp_norm_r3.
//   EXP_W / MANT_W / SUM_W : exponent, stored fraction and raw magnitude widths
//   EXP_MAX                : saturation value for the exponent
//   RM_*                   : rounding-mode encodings carried to the rounder
//   fp_norm_payload_t      : everything stage A holds for one result
package fp_pkg;

  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int SUM_W  = 28;

  localparam logic [EXP_W-1:0] EXP_MAX = 8'd255;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef struct packed {
    logic [SUM_W-1:0] sum_mant;
    logic [EXP_W-1:0] exp_in;
    logic [4:0]       lzc;
    logic             sign;
    logic             nan;
    logic             inf1;
    logic             inf2;
    logic             sign1;
    logic             sign2;
    logic [2:0]       rm;
  } fp_norm_payload_t;

endpackage

// File: rtl/fp_norm_r3_if.sv
// fp_norm_r3_if: input payload + valid/ready, flush, and the normalized
// output payload + valid/ready of the normalizer.
//   master : the side that supplies inputs and consumes outputs
//   slave  : the normalizer itself
interface fp_norm_r3_if;
  import fp_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic [SUM_W-1:0]  sum_mant;
  logic [EXP_W-1:0]  exp_in;
  logic              sign_in;
  logic              nan_in;
  logic              inf1_in;
  logic              inf2_in;
  logic              sign1_in;
  logic              sign2_in;
  logic [2:0]        rm_in;

  logic              out_valid;
  logic              out_ready;
  logic [EXP_W-1:0]  exp_norm;
  logic [MANT_W-1:0] mantissa_norm;
  logic [2:0]        grs;
  logic              res_is_zero;
  logic              underflow;
  logic              sign_res;
  logic              nan;
  logic              inf1;
  logic              inf2;
  logic              sign1;
  logic              sign2;
  logic [2:0]        rm;

  modport master (
    output in_valid, flush, sum_mant, exp_in, sign_in, nan_in, inf1_in,
           inf2_in, sign1_in, sign2_in, rm_in, out_ready,
    input  in_ready, out_valid, exp_norm, mantissa_norm, grs, res_is_zero,
           underflow, sign_res, nan, inf1, inf2, sign1, sign2, rm
  );

  modport slave (
    input  in_valid, flush, sum_mant, exp_in, sign_in, nan_in, inf1_in,
           inf2_in, sign1_in, sign2_in, rm_in, out_ready,
    output in_ready, out_valid, exp_norm, mantissa_norm, grs, res_is_zero,
           underflow, sign_res, nan, inf1, inf2, sign1, sign2, rm
  );

endinterface

// File: rtl/fp_norm_r3_lzc27.sv
// lzc27: combinational leading-zero count of a 27-bit vector.
//   d   : vector to scan, bit 26 is the most significant
//   cnt : number of zeros above the leading one, 27 when d is all zero
module lzc27 (
  input  logic [26:0] d,
  output logic [4:0]  cnt
);

  // Scanning upward lets the highest set bit overwrite lower hits.
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (d[i]) cnt = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_norm_r3.sv
// fp_norm_r3: two-stage normalizer between the mantissa adder and the
// rounder. Stage A captures the raw sum, exponent, flags and its leading-zero
// count; stage B registers the normalized exponent, fraction, G/R/S and the
// zero/underflow indications. The whole pipe advances together whenever the
// output register is empty or being taken.
//   clk     : clock, rising edge
//   reset_n : synchronous active-low reset
//   bus     : fp_norm_r3_if slave (input payload, flush, output payload)
module fp_norm_r3
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  fp_norm_r3_if.slave  bus
);

  logic             adv;
  logic [4:0]       lzc_in;
  fp_norm_payload_t payload_d;
  fp_norm_payload_t a_q;
  logic             a_valid;

  logic              out_valid_q;
  logic [EXP_W-1:0]  exp_q;
  logic [MANT_W-1:0] mant_q;
  logic [2:0]        grs_q;
  logic              zero_q;
  logic              uf_q;
  logic              sign_q, nan_q, inf1_q, inf2_q, sign1_q, sign2_q;
  logic [2:0]        rm_q;

  logic [EXP_W-1:0]  n_exp;
  logic [MANT_W-1:0] n_mant;
  logic [2:0]        n_grs;
  logic              n_zero;
  logic              n_uf;
  logic [4:0]        shamt;
  logic [25:0]       shifted;
  logic signed [9:0] exp_s;
  logic signed [9:0] lz_s;
  logic signed [9:0] exp_calc;

  assign adv          = !out_valid_q || bus.out_ready;
  assign bus.in_ready = adv;

  lzc27 u_lzc (
    .d   (bus.sum_mant[26:0]),
    .cnt (lzc_in)
  );

  always_comb begin
    payload_d.sum_mant = bus.sum_mant;
    payload_d.exp_in   = bus.exp_in;
    payload_d.lzc      = lzc_in;
    payload_d.sign     = bus.sign_in;
    payload_d.nan      = bus.nan_in;
    payload_d.inf1     = bus.inf1_in;
    payload_d.inf2     = bus.inf2_in;
    payload_d.sign1    = bus.sign1_in;
    payload_d.sign2    = bus.sign2_in;
    payload_d.rm       = bus.rm_in;
  end

  assign exp_s = signed'({2'b00, a_q.exp_in});
  assign lz_s  = signed'({5'b00000, a_q.lzc});

  // Only bits [25:0] of the left-shifted magnitude survive: bit 26 becomes the
  // hidden bit (or is zero in the underflow case) and is dropped either way.
  always_comb begin
    n_exp    = '0;
    n_mant   = '0;
    n_grs    = '0;
    n_zero   = 1'b0;
    n_uf     = 1'b0;
    shamt    = '0;
    shifted  = '0;
    exp_calc = '0;
    if (a_q.sum_mant == '0) begin
      n_zero = 1'b1;
    end else if (a_q.sum_mant[27]) begin
      exp_calc = exp_s + 10'sd1;
      n_exp    = (exp_calc > 10'sd255) ? EXP_MAX : exp_calc[7:0];
      n_mant   = a_q.sum_mant[26:4];
      n_grs    = {a_q.sum_mant[3], a_q.sum_mant[2],
                  a_q.sum_mant[1] | a_q.sum_mant[0]};
    end else begin
      if (exp_s > lz_s) begin
        shamt    = a_q.lzc;
        exp_calc = exp_s - lz_s;
        n_exp    = exp_calc[7:0];
      end else begin
        // exp_in <= lzc <= 27 here, so exp_in-1 fits the 5-bit shift amount.
        n_uf  = 1'b1;
        shamt = (a_q.exp_in == '0) ? 5'd0 : (a_q.exp_in[4:0] - 5'd1);
      end
      shifted = a_q.sum_mant[25:0] << shamt;
      n_mant  = shifted[25:3];
      n_grs   = shifted[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_valid     <= 1'b0;
      a_q         <= '0;
      out_valid_q <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      grs_q       <= '0;
      zero_q      <= 1'b0;
      uf_q        <= 1'b0;
      sign_q      <= 1'b0;
      nan_q       <= 1'b0;
      inf1_q      <= 1'b0;
      inf2_q      <= 1'b0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      rm_q        <= '0;
    end else if (bus.flush) begin
      a_valid     <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      a_valid     <= bus.in_valid;
      out_valid_q <= a_valid;
      if (bus.in_valid) a_q <= payload_d;
      if (a_valid) begin
        exp_q   <= n_exp;
        mant_q  <= n_mant;
        grs_q   <= n_grs;
        zero_q  <= n_zero;
        uf_q    <= n_uf;
        sign_q  <= a_q.sign;
        nan_q   <= a_q.nan;
        inf1_q  <= a_q.inf1;
        inf2_q  <= a_q.inf2;
        sign1_q <= a_q.sign1;
        sign2_q <= a_q.sign2;
        rm_q    <= a_q.rm;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.exp_norm      = exp_q;
  assign bus.mantissa_norm = mant_q;
  assign bus.grs           = grs_q;
  assign bus.res_is_zero   = zero_q;
  assign bus.underflow     = uf_q;
  assign bus.sign_res      = sign_q;
  assign bus.nan           = nan_q;
  assign bus.inf1          = inf1_q;
  assign bus.inf2          = inf2_q;
  assign bus.sign1         = sign1_q;
  assign bus.sign2         = sign2_q;
  assign bus.rm            = rm_q;

endmodule

// File: tb/tb_fp_norm_r3.sv
// tb_fp_norm_r3: directed and randomized checks of fp_norm_r3 against an
// arithmetic reference model with an in-order expectation queue.
module tb_fp_norm_r3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fp_norm_r3_if bus ();

  fp_norm_r3 dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0]  exp;
    logic [22:0] mant;
    logic [2:0]  grs;
    logic        zero;
    logic        uf;
    logic [8:0]  misc;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_checks++;
    if (obs !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, req, cyc);
    end
  endtask

  function automatic exp_t ref_norm(input logic [27:0] s, input logic [7:0] e, input logic [8:0] misc);
    exp_t   r;
    longint v;
    longint sv;
    int     ei;
    int     t;
    int     p;
    int     lz;
    int     sh;
    v = longint'(s);
    ei = int'(e);
    r.exp = '0; r.mant = '0; r.grs = '0; r.zero = 1'b0; r.uf = 1'b0;
    r.misc = misc; r.acc = 0;
    if (v == 0) begin
      r.zero = 1'b1;
    end else if (v >= 64'h8000000) begin
      t = ei + 1;
      if (t > 255) t = 255;
      r.exp  = 8'(t);
      r.mant = 23'(v >> 4);
      r.grs  = 3'(((v >> 3) & 1) * 4 + ((v >> 2) & 1) * 2 + (((v & 3) != 0) ? 1 : 0));
    end else begin
      p = 0;
      while ((64'd1 << (p + 1)) <= v) p++;
      lz = 26 - p;
      if (ei > lz) begin
        sh = lz;
        r.exp = 8'(ei - lz);
      end else begin
        r.uf = 1'b1;
        sh = (ei == 0) ? 0 : ei - 1;
      end
      sv = (v << sh) & 64'h7ffffff;
      r.mant = 23'(sv >> 3);
      r.grs  = 3'(sv);
    end
    return r;
  endfunction

  // One clock of stimulus; the expectation queue tracks what must come out.
  task automatic step(input logic iv, input logic [27:0] s, input logic [7:0] e,
                      input logic [8:0] misc, input logic ordy, input logic fl);
    exp_t h;
    exp_t n;
    logic exp_ov;
    bus.in_valid  = iv;
    bus.sum_mant  = s;
    bus.exp_in    = e;
    {bus.sign_in, bus.nan_in, bus.inf1_in, bus.inf2_in,
     bus.sign1_in, bus.sign2_in, bus.rm_in} = misc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    exp_ov = (q.size() > 0) && (cyc >= q[0].acc + 2);
    check_val("out_valid", 64'(bus.out_valid), 64'(exp_ov));
    check_val("in_ready", 64'(bus.in_ready), 64'(!exp_ov || ordy));
    if (exp_ov) begin
      h = q[0];
      check_val("out_data",
                64'({bus.exp_norm, bus.mantissa_norm, bus.grs, bus.res_is_zero, bus.underflow,
                     bus.sign_res, bus.nan, bus.inf1, bus.inf2, bus.sign1, bus.sign2, bus.rm}),
                64'({h.exp, h.mant, h.grs, h.zero, h.uf, h.misc}));
      if (ordy) void'(q.pop_front());
    end
    if (fl) begin
      q.delete();
    end else if (iv && (!exp_ov || ordy)) begin
      n = ref_norm(s, e, misc);
      n.acc = cyc;
      q.push_back(n);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 28'h0, 8'h0, 9'h0, ordy, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [7:0] e, input logic [22:0] m,
                            input logic [2:0] g, input logic uf, input logic z);
    check_val({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
    check_val(tag, 64'({bus.exp_norm, bus.mantissa_norm, bus.grs, bus.underflow, bus.res_is_zero}),
              64'({e, m, g, uf, z}));
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.in_valid  = 1'b1;
    bus.sum_mant  = 28'h1234567;
    bus.exp_in    = 8'd50;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    reset_n = 1'b1;
    bus.in_valid = 1'b0;
    q.delete();
    #1;
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_data", 64'({bus.exp_norm, bus.mantissa_norm, bus.grs, bus.res_is_zero, bus.underflow,
                                bus.sign_res, bus.nan, bus.inf1, bus.inf2, bus.sign1, bus.sign2, bus.rm}),
              64'd0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [27:0] s;
    logic [7:0]  e;
    int          sel;
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    bus.sum_mant = '0; bus.exp_in = '0;
    {bus.sign_in, bus.nan_in, bus.inf1_in, bus.inf2_in,
     bus.sign1_in, bus.sign2_in, bus.rm_in} = '0;
    @(posedge clk);
    #1;
    do_reset();

    // carry, two-cycle latency
    step(1'b1, 28'h8000000, 8'd127, 9'h0, 1'b1, 1'b0);
    check_val("lat_not_yet", 64'(bus.out_valid), 64'd0);
    idle(1'b0);
    expect_out("carry127", 8'd128, 23'h0, 3'd0, 1'b0, 1'b0);
    idle(1'b1);

    // normal left shift
    step(1'b1, 28'h0000008, 8'd100, 9'h0, 1'b1, 1'b0);
    idle(1'b0);
    expect_out("lshift", 8'd77, 23'h0, 3'd0, 1'b0, 1'b0);
    idle(1'b1);

    // underflow
    step(1'b1, 28'h0000008, 8'd10, 9'h0, 1'b1, 1'b0);
    idle(1'b0);
    expect_out("uflow", 8'd0, 23'h000200, 3'd0, 1'b1, 1'b0);
    idle(1'b1);

    // saturation then zero, back to back
    step(1'b1, 28'h8000000, 8'd254, 9'h0, 1'b0, 1'b0);
    step(1'b1, 28'h0, 8'd90, 9'h0, 1'b0, 1'b0);
    expect_out("carry254", 8'd255, 23'h0, 3'd0, 1'b0, 1'b0);
    idle(1'b1);
    expect_out("zero", 8'd0, 23'h0, 3'd0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // three back-to-back with a 3-cycle stall
    step(1'b1, 28'h0123456, 8'd60, 9'h1a5, 1'b0, 1'b0);
    step(1'b1, 28'h9abcdef, 8'd200, 9'h04b, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 28'h0000f0f, 8'd30, 9'h132, 1'b0, 1'b0);
    step(1'b1, 28'h0000f0f, 8'd30, 9'h132, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) idle(1'b1);
    check_val("stall_drained", 64'(q.size()), 64'd0);

    // flush with both stages full and an input offered
    step(1'b1, 28'h5555555, 8'd40, 9'h011, 1'b0, 1'b0);
    step(1'b1, 28'h2222222, 8'd41, 9'h022, 1'b0, 1'b0);
    step(1'b1, 28'h7777777, 8'd42, 9'h033, 1'b0, 1'b1);
    check_val("flush_out_valid", 64'(bus.out_valid), 64'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // reset mid-operation discards in-flight items
    step(1'b1, 28'h0345678, 8'd120, 9'h0ff, 1'b0, 1'b0);
    step(1'b1, 28'h0345679, 8'd121, 9'h0fe, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) idle(1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      s = 28'h0;
      else if (sel <= 2) s = {1'b1, 27'($urandom)};
      else               s = 28'($urandom) >> $urandom_range(1, 27);
      sel = $urandom_range(0, 9);
      case (sel)
        0: e = 8'd0;
        1: e = 8'd1;
        2: e = 8'd254;
        3: e = 8'd255;
        4: e = 8'($urandom_range(0, 30));
        default: e = 8'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, s, e, 9'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) idle(1'b1);
    check_val("final_drain", 64'(q.size()), 64'd0);
    idle(1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
